// File: rtl/banked_ram_pkg.sv
// Shared sizing helpers and response descriptor for the banked RAM arbiter.
package banked_ram_pkg;

    localparam int RESP_BANK_W = 8;

    // Index width that never collapses to zero bits for single-entry structures.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bo_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int bank_bits(input int num_banks);
        return idx_w(num_banks);
    endfunction

    function automatic int row_bits(input int num_words, input int num_banks);
        return idx_w(num_words / num_banks);
    endfunction

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [RESP_BANK_W-1:0] bank_idx;
    } resp_t;

endpackage

// File: rtl/bank_rr_arb.sv
// Round-robin arbiter for one bank: the pointer names the highest-priority port.
module bank_rr_arb
    import banked_ram_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt
);

    localparam int PW = idx_w(NUM_PORTS);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            idx;

    // Scan ports starting at the pointer; first requester wins and the pointer moves past it.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(ptr_q) + i) % NUM_PORTS;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                ptr_d    = PW'((idx + 1) % NUM_PORTS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/banked_ram_arb.sv
// Multi-port word-interleaved RAM: N ports share M byte-lane BRAM banks,
// each bank with its own round-robin arbiter and a req/gnt/rvalid handshake.
module banked_ram_arb
    import banked_ram_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 8192,
    parameter int OUT_REG    = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0]                 req_i,
    output logic [NUM_PORTS-1:0]                 gnt_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      addr_i,
    input  logic [NUM_PORTS-1:0]                 we_i,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]  be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      wdata_i,
    output logic [NUM_PORTS-1:0]                 rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]      rdata_o
);

    localparam int BO   = bo_w(DATA_WIDTH);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int BW   = bank_bits(NUM_BANKS);
    localparam int RW   = row_bits(NUM_WORDS, NUM_BANKS);
    localparam int ROWS = NUM_WORDS / NUM_BANKS;
    localparam int WW   = ADDR_WIDTH - BO;

    logic [BW-1:0]         port_bank [NUM_PORTS];
    logic [RW-1:0]         port_row  [NUM_PORTS];
    logic [WW-1:0]         dec_word;
    logic [NUM_PORTS-1:0]  bank_req  [NUM_BANKS];
    logic [NUM_PORTS-1:0]  bank_gnt  [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    resp_t                 resp_q    [NUM_PORTS];
    logic [NUM_PORTS-1:0]  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data [NUM_PORTS];
    logic [DATA_WIDTH-1:0] hold_q    [NUM_PORTS];
    logic                  unused_addr;

    // Byte-offset bits are dropped by the word split below.
    assign unused_addr = ^addr_i;

    // Bank is the low word bits, row the next bits; anything above wraps.
    always_comb begin
        dec_word = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            dec_word     = addr_i[p*ADDR_WIDTH+BO +: WW];
            port_bank[p] = BW'(32'(dec_word) % NUM_BANKS);
            port_row[p]  = RW'((32'(dec_word) / NUM_BANKS) % ROWS);
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                bank_req[b][p] = rst_n & req_i[p] & (port_bank[p] == BW'(b));
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt_o = gnt_o | bank_gnt[b];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                  en;
        logic                  we;
        logic [NB-1:0]         be;
        logic [DATA_WIDTH-1:0] wdata;
        logic [DATA_WIDTH-1:0] rdata;
        logic [RW-1:0]         row;

        bank_rr_arb #(
            .NUM_PORTS(NUM_PORTS)
        ) u_arb (
            .clk  (clk),
            .rst_n(rst_n),
            .req  (bank_req[b]),
            .gnt  (bank_gnt[b])
        );

        // At most one grant per bank, so the winner's request is steered straight in.
        always_comb begin
            en    = 1'b0;
            we    = 1'b0;
            be    = '0;
            wdata = '0;
            row   = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bank_gnt[b][p]) begin
                    en    = 1'b1;
                    we    = we_i[p];
                    be    = be_i[p*NB +: NB];
                    wdata = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                    row   = port_row[p];
                end
            end
        end

        for (genvar l = 0; l < NB; l++) begin : g_lane
            logic [7:0] mem [ROWS];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) begin
                        if (be[l]) begin
                            mem[row] <= wdata[l*8 +: 8];
                        end
                    end else begin
                        rd_q <= mem[row];
                    end
                end
            end

            assign rdata[l*8 +: 8] = rd_q;
        end

        assign bank_rdata[b] = rdata;
    end

    // Remember which bank each accepted request went to so its data can be routed back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                resp_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                resp_q[p].valid    <= gnt_o[p];
                resp_q[p].is_write <= we_i[p];
                resp_q[p].bank_idx <= RESP_BANK_W'(port_bank[p]);
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            resp_valid[p] = resp_q[p].valid;
            resp_data[p]  = '0;
            if (!resp_q[p].is_write) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (resp_q[p].bank_idx == RESP_BANK_W'(b)) begin
                        resp_data[p] = bank_rdata[b];
                    end
                end
            end
        end
    end

    // Last response per port; doubles as the output register when OUT_REG is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                hold_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (resp_q[p].valid) begin
                    hold_q[p] <= resp_data[p];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [NUM_PORTS-1:0] out_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q <= '0;
            end else begin
                out_valid_q <= resp_valid;
            end
        end

        always_comb begin
            rvalid_o = out_valid_q;
            rdata_o  = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = hold_q[p];
            end
        end
    end else begin : g_no_out_reg
        always_comb begin
            rvalid_o = resp_valid;
            rdata_o  = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = resp_valid[p] ? resp_data[p] : hold_q[p];
            end
        end
    end

endmodule

// File: tb/tb_banked_ram_arb.sv
// Bench for banked_ram_arb: two instances (OUT_REG=0 / ADDR_WIDTH=16 OUT_REG=1) share one stimulus stream.
module tb_banked_ram_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [3:0]  b0;
    logic [3:0]  b1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  gnt0;
    logic [1:0]  gnt1;
    logic [1:0]  rv0;
    logic [1:0]  rv1;
    logic [63:0] rd0;
    logic [63:0] rd1;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mem_w [8192];
    int          ptr [4];
    logic [31:0] held [2][2];
    logic [1:0]  pend;
    logic [31:0] pend_data [2];
    logic [1:0]  dut_gnt;

    always #5 clk = ~clk;

    banked_ram_arb #(.OUT_REG(0)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req),
        .gnt_o   (gnt0),
        .addr_i  ({a1[14:0], a0[14:0]}),
        .we_i    (we),
        .be_i    ({b1, b0}),
        .wdata_i ({d1, d0}),
        .rvalid_o(rv0),
        .rdata_o (rd0)
    );

    banked_ram_arb #(.ADDR_WIDTH(16), .OUT_REG(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req),
        .gnt_o   (gnt1),
        .addr_i  ({a1, a0}),
        .we_i    (we),
        .be_i    ({b1, b0}),
        .wdata_i ({d1, d0}),
        .rvalid_o(rv1),
        .rdata_o (rd1)
    );

    // 32 KiB of storage, so every byte address folds modulo 2^15.
    function automatic int word_of(input logic [15:0] a);
        return (int'(a) % 32768) / 4;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [15:0] x0, input logic [15:0] x1,
                                 input logic [1:0] w, input logic [3:0] e0, input logic [3:0] e1,
                                 input logic [31:0] v0, input logic [31:0] v1);
        req = r; a0 = x0; a1 = x1; we = w; b0 = e0; b1 = e1; d0 = v0; d1 = v1;
    endtask

    task automatic modelReset();
        for (int k = 0; k < 4; k++) ptr[k] = 0;
        for (int u = 0; u < 2; u++) begin
            for (int p = 0; p < 2; p++) held[u][p] = 32'h0;
            pend_data[u] = 32'h0;
        end
        pend = 2'b00;
    endtask

    // One clock: drive, predict grants, apply the accepted accesses to the model, check responses.
    task automatic runCycle(input logic [1:0] r, input logic [15:0] x0, input logic [15:0] x1,
                            input logic [1:0] w, input logic [3:0] e0, input logic [3:0] e1,
                            input logic [31:0] v0, input logic [31:0] v1);
        logic [1:0]  eg;
        logic [1:0]  exp_rv1;
        logic [15:0] aa [2];
        logic [3:0]  bb [2];
        logic [31:0] dd [2];
        logic [31:0] rdv [2];
        logic        found;
        int          cand;
        int          wi;
        applyStimulus(r, x0, x1, w, e0, e1, v0, v1);
        aa[0] = x0; aa[1] = x1; bb[0] = e0; bb[1] = e1; dd[0] = v0; dd[1] = v1;
        #1;
        eg = 2'b00;
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                found = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    cand = (ptr[k] + j) % 2;
                    if (!found && r[cand] && (word_of(aa[cand]) % 4 == k)) begin
                        eg[cand] = 1'b1;
                        found    = 1'b1;
                        ptr[k]   = (cand + 1) % 2;
                    end
                end
            end
        end
        dut_gnt = gnt0;
        checkOutput("gnt_outreg0", 64'(gnt0), 64'(eg));
        checkOutput("gnt_outreg1", 64'(gnt1), 64'(eg));
        for (int p = 0; p < 2; p++) begin
            rdv[p] = (eg[p] && !w[p]) ? mem_w[word_of(aa[p])] : 32'h0;
        end
        for (int p = 0; p < 2; p++) begin
            if (eg[p] && w[p]) begin
                wi = word_of(aa[p]);
                for (int i = 0; i < 4; i++) begin
                    if (bb[p][i]) mem_w[wi][8*i +: 8] = dd[p][8*i +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            exp_rv1 = pend;
            for (int p = 0; p < 2; p++) begin
                if (eg[p])   held[0][p] = rdv[p];
                if (pend[p]) held[1][p] = pend_data[p];
                pend_data[p] = rdv[p];
            end
            pend = eg;
        end else begin
            modelReset();
            exp_rv1 = 2'b00;
        end
        checkOutput("rvalid_outreg0", 64'(rv0), rst_n ? 64'(eg) : 64'h0);
        checkOutput("rvalid_outreg1", 64'(rv1), 64'(exp_rv1));
        checkOutput("rdata_outreg0", rd0, {held[0][1], held[0][0]});
        checkOutput("rdata_outreg1", rd1, {held[1][1], held[1][0]});
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus(2'b00, 16'h0, 16'h0, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
        modelReset();
        #1 rst_n = 1'b0;
        @(negedge clk);

        // Reset held with both ports requesting.
        for (int i = 0; i < 3; i++) runCycle(2'b11, 16'h0010, 16'h0024, 2'b00, 4'hF, 4'hF, 32'h0, 32'h0);
        rst_n = 1'b1;

        // Fill words 0..15; the two ports always hit different banks.
        for (int i = 0; i < 8; i++) runCycle(2'b11, 16'(8*i), 16'(8*i+4), 2'b11, 4'hF, 4'hF, $urandom, $urandom);

        runCycle(2'b01, 16'h0010, 16'h0, 2'b01, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0);
        checkOutput("t2_write_rvalid", 64'(rv0[0]), 64'h1);
        checkOutput("t2_write_rdata", 64'(rd0[31:0]), 64'h0);
        runCycle(2'b01, 16'h0010, 16'h0, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
        checkOutput("t2_read_rdata", 64'(rd0[31:0]), 64'hDEADBEEF);

        runCycle(2'b01, 16'h0010, 16'h0, 2'b01, 4'b0001, 4'h0, 32'h000000AA, 32'h0);
        runCycle(2'b01, 16'h0010, 16'h0, 2'b01, 4'b0000, 4'h0, 32'hFFFFFFFF, 32'h0);
        runCycle(2'b01, 16'h0010, 16'h0, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
        checkOutput("t3_be_rdata", 64'(rd0[31:0]), 64'hDEADBEAA);

        runCycle(2'b11, 16'h0000, 16'h0004, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
        checkOutput("t4_parallel_gnt", 64'(dut_gnt), 64'h3);

        // Reset while a write has landed and responses are still in flight.
        runCycle(2'b11, 16'h000C, 16'h0004, 2'b01, 4'hF, 4'h0, 32'h12345678, 32'h0);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midreset_rvalid0", 64'(rv0), 64'h0);
        checkOutput("midreset_rvalid1", 64'(rv1), 64'h0);
        checkOutput("midreset_rdata0", rd0, 64'h0);
        checkOutput("midreset_rdata1", rd1, 64'h0);
        runCycle(2'b00, 16'h0, 16'h0, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        runCycle(2'b01, 16'h000C, 16'h0, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
        checkOutput("midreset_write_kept", 64'(rd0[31:0]), 64'h12345678);

        for (int k = 0; k < 4; k++) begin
            runCycle(2'b11, 16'h0008, 16'h0028, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
            checkOutput("t5_rr_gnt", 64'(dut_gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
        end

        runCycle(2'b01, 16'h8010, 16'h0, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
        checkOutput("t6_outreg_early", 64'(rv1[0]), 64'h0);
        runCycle(2'b00, 16'h0, 16'h0, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0);
        checkOutput("t6_outreg_rvalid", 64'(rv1[0]), 64'h1);
        checkOutput("t6_wrap_rdata", 64'(rd1[31:0]), 64'hDEADBEAA);

        // Random traffic over the initialised words, with bit 15 set at random to exercise the wrap.
        for (int i = 0; i < 300; i++) begin
            runCycle(2'($urandom), 16'($urandom & 32'h803F), 16'($urandom & 32'h803F), 2'($urandom),
                     4'($urandom), 4'($urandom), $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
